// File: rtl/rld_pkg.sv
// Shared types and helpers for the run-length matcher.
package rld_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SAT
    } state_t;

    // Longest run the counter can represent before saturating.
    function automatic int unsigned max_run(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/rld_run_counter.sv
// Saturating run counter; clear takes priority over increment.
module rld_run_counter
    import rld_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_max_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(max_run(CNT_W));

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_CNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q == MAX_CNT);

endmodule

// File: rtl/run_length_matcher.sv
// Serial run detector: reports terminated runs of 1s and flags lengths set in a mask.
// Optional sticky saturation flag `ovf` when RUN_LEN_MATCHER_OVF_EN is defined.
module run_length_matcher
    import rld_pkg::*;
#(
    parameter int unsigned              CNT_W      = 3,
    parameter logic [(1<<CNT_W)-1:0]    MATCH_MASK = 8'b0001_0100,
    parameter bit                       SAT_MATCH  = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    input_bit,
    input  logic                    mask_load,
    input  logic [(1<<CNT_W)-1:0]   mask_in,
`ifdef RUN_LEN_MATCHER_OVF_EN
    output logic                    ovf,
`endif
    output logic                    output_bit,
    output logic                    run_valid,
    output logic [CNT_W-1:0]        run_len,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(max_run(CNT_W) - 1);

    state_t state_q, state_d;

    logic                    inc, clr, term, match_d;
    logic [CNT_W-1:0]        count;
    logic                    at_max;
    logic [(1<<CNT_W)-1:0]   mask_q;
    logic                    run_valid_q, match_q;
    logic [CNT_W-1:0]        run_len_q;

    rld_run_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .inc_i    (inc),
        .clr_i    (clr),
        .count_o  (count),
        .at_max_o (at_max)
    );

    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        clr     = 1'b0;
        term    = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (input_bit) begin
                        inc     = 1'b1;
                        // Only reaches SAT directly when MAX_RUN is 1.
                        state_d = (count == PRE_MAX) ? SAT : RUN;
                    end
                end
                RUN: begin
                    if (input_bit) begin
                        inc = 1'b1;
                        if (count == PRE_MAX) begin
                            state_d = SAT;
                        end
                    end else begin
                        term    = 1'b1;
                        clr     = 1'b1;
                        state_d = IDLE;
                    end
                end
                SAT: begin
                    if (!input_bit) begin
                        term    = 1'b1;
                        clr     = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Saturated runs only match when SAT_MATCH allows it; old mask is used on a load cycle.
    assign match_d = term && mask_q[count] && ((state_q != SAT) || SAT_MATCH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mask_q      <= MATCH_MASK;
            run_valid_q <= 1'b0;
            run_len_q   <= '0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_valid_q <= term;
            run_len_q   <= term ? count : '0;
            match_q     <= match_d;
            if (mask_load) begin
                mask_q <= mask_in;
            end
        end
    end

`ifdef RUN_LEN_MATCHER_OVF_EN
    logic ovf_q, ovf_d;

    // Setting has priority over a simultaneous mask_load clear.
    always_comb begin
        ovf_d = ovf_q;
        if (state_d == SAT) begin
            ovf_d = 1'b1;
        end else if (mask_load) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign output_bit = match_q;
    assign run_valid  = run_valid_q;
    assign run_len    = run_len_q;
    assign busy       = (state_q != IDLE);

    logic unused_at_max;
    assign unused_at_max = at_max;

endmodule

// File: tb/tb_run_length_matcher.sv
// Self-checking bench for run_length_matcher against an integer run-length model.
module tb_run_length_matcher;

    localparam bit SAT_MATCH = 1'b0;
    localparam int MAX_RUN   = 7;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       input_bit = 1'b0;
    logic       mask_load = 1'b0;
    logic [7:0] mask_in = 8'h00;
    logic       output_bit, run_valid, busy;
    logic [2:0] run_len;
`ifdef RUN_LEN_MATCHER_OVF_EN
    logic       ovf;
`endif

    run_length_matcher dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .input_bit  (input_bit),
        .mask_load  (mask_load),
        .mask_in    (mask_in),
`ifdef RUN_LEN_MATCHER_OVF_EN
        .ovf        (ovf),
`endif
        .output_bit (output_bit),
        .run_valid  (run_valid),
        .run_len    (run_len),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Model: unbounded count of consecutive valid 1s plus expected outputs.
    int         run    = 0;
    logic [7:0] mask_m = 8'h14;
    logic       e_rv = 1'b0, e_ob = 1'b0, e_busy = 1'b0, e_ovf = 1'b0;
    logic [2:0] e_len = 3'd0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        run    = 0;
        mask_m = 8'h14;
        e_rv   = 1'b0;
        e_ob   = 1'b0;
        e_len  = 3'd0;
        e_busy = 1'b0;
        e_ovf  = 1'b0;
    endtask

    task automatic model_update();
        int len;
        e_rv  = 1'b0;
        e_ob  = 1'b0;
        e_len = 3'd0;
        if (in_valid) begin
            if (input_bit) begin
                run++;
            end else if (run > 0) begin
                len   = (run >= MAX_RUN) ? MAX_RUN : run;
                e_rv  = 1'b1;
                e_len = 3'(len);
                e_ob  = (run >= MAX_RUN) ? (SAT_MATCH && mask_m[MAX_RUN]) : mask_m[len];
                run   = 0;
            end
        end
        if (run >= MAX_RUN) begin
            e_ovf = 1'b1;
        end else if (mask_load) begin
            e_ovf = 1'b0;
        end
        if (mask_load) begin
            mask_m = mask_in;
        end
        e_busy = (run > 0);
    endtask

    task automatic step_ml(input logic v, input logic b, input logic ml, input logic [7:0] mi);
        in_valid  = v;
        input_bit = b;
        mask_load = ml;
        mask_in   = mi;
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic step(input logic v, input logic b);
        step_ml(v, b, 1'b0, 8'h00);
    endtask

    always @(negedge clock) begin
        chk("run_valid", run_valid, e_rv);
        chk("run_len", run_len, e_len);
        chk("output_bit", output_bit, e_ob);
        chk("busy", busy, e_busy);
`ifdef RUN_LEN_MATCHER_OVF_EN
        chk("ovf", ovf, e_ovf);
`endif
    end

    initial begin
        model_reset();
        @(posedge clock);
        #1;
        chk("reset_run_valid", run_valid, 0);
        chk("reset_output_bit", output_bit, 0);
        chk("reset_busy", busy, 0);
        chk("reset_run_len", run_len, 0);
        @(posedge clock);
        #1 reset = 1'b1;

        // 0,1,1,0 -> length 2 matches default mask
        step(1, 0); step(1, 1); step(1, 1); step(1, 0);
        chk("t1_rv", run_valid, 1);
        chk("t1_len", run_len, 2);
        chk("t1_ob", output_bit, 1);
        step(1, 0);
        chk("t1_pulse_end", run_valid, 0);

        // 3-run misses, 4-run matches
        step(1, 1); step(1, 1); step(1, 1); step(1, 0);
        chk("t2a_len", run_len, 3);
        chk("t2a_ob", output_bit, 0);
        for (int i = 0; i < 4; i++) step(1, 1);
        step(1, 0);
        chk("t2b_len", run_len, 4);
        chk("t2b_ob", output_bit, 1);

        // run spanning an invalid gap
        step(1, 1); step(1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            chk("t5_gap_rv", run_valid, 0);
            chk("t5_gap_busy", busy, 1);
        end
        step(1, 0);
        chk("t5_len", run_len, 2);
        chk("t5_ob", output_bit, 1);

        // saturation
        for (int i = 0; i < 9; i++) begin
            step(1, 1);
            chk("t3_busy", busy, 1);
        end
        step(1, 0);
        chk("t3_rv", run_valid, 1);
        chk("t3_len", run_len, 7);
        chk("t3_ob", output_bit, 0);
`ifdef RUN_LEN_MATCHER_OVF_EN
        chk("t3_ovf", ovf, 1);
        step(1, 0);
        chk("t3_ovf_hold", ovf, 1);
`endif

        // asynchronous reset mid-run
        step(1, 1); step(1, 1); step(1, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_rv", run_valid, 0);
        chk("t6_ob", output_bit, 0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        step(1, 0);
        chk("t6_after_rv", run_valid, 0);

        // mask load coincident with terminate uses old mask
        step(1, 1); step(1, 1); step(1, 1);
        step_ml(1, 0, 1, 8'h08);
        chk("t4_rv", run_valid, 1);
        chk("t4_old_mask_ob", output_bit, 0);
        step(1, 1); step(1, 1); step(1, 1); step(1, 0);
        chk("t4_new_mask_ob", output_bit, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic v, b, ml;
            logic [7:0] mi;
            v  = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 6 : 8));
            ml = ($urandom_range(0, 31) == 0);
            mi = 8'($urandom);
            step_ml(v, b, ml, mi);
        end
        step(1, 0);
        step(1, 0);
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
